ar_rx_sched: RTL

AR_RX_SCHED -- requirements
Module: ar_rx_sched

---
 rtl/ar429_pkg.sv | 16 +
 rtl/ar_rr_pick.sv | 29 ++
 rtl/ar_rx_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ar429_pkg.sv
// Shared widths, default channel count and scheduler FSM states for the ARINC 429 receive merge.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ar429_pkg;

  localparam int ADR_W   = 8;   // label width
  localparam int DAT_W   = 23;  // data field width
  localparam int NCH_DEF = 4;   // default number of merged receive channels
  localparam int IDX_W   = 3;   // channel index width, covers up to 8 channels

  typedef enum logic {
    IDLE    = 1'b0,  // output register empty
    PRESENT = 1'b1   // output register holds a word, out_valid high
  } sched_state_e;

endpackage

// File: rtl/ar_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NCH.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides whether the grant is consumed.
module ar_rr_pick
  import ar429_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  // Scan candidates farthest-first so the nearest requester after 'last' overwrites the rest.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      if (req[SEL_W'((int'(last) + i) % NCH)]) begin
        grant = IDX_W'((int'(last) + i) % NCH);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_rx_sched.sv
// Merges NCH ARINC 429 receive channels (one-word slot each) into one stream; optional label filter under AR_LABEL_FILTER_EN.
// Latency: ch_wr in cycle n gives out_valid in cycle n+2 when idle; back-to-back words with no bubble.
// Backpressure: out_valid/out_ready; a word arriving at a full, undrained slot is dropped and sets sticky ovr.
module ar_rx_sched
  import ar429_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*DAT_W-1:0] ch_dat,
  input  logic [NCH*ADR_W-1:0] ch_adr,
  input  logic [NCH-1:0]     ch_wr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DAT_W-1:0]   out_dat,
  output logic [ADR_W-1:0]   out_adr,
  output logic [IDX_W-1:0]   out_ch,
  output logic [NCH-1:0]     ovr,
  input  logic [NCH-1:0]     ovr_clr
`ifdef AR_LABEL_FILTER_EN
  ,
  input  logic               lbl_wr,
  input  logic [ADR_W-1:0]   lbl_sel,
  input  logic               lbl_acc
`endif
);

  sched_state_e     state_q, state_d;
  logic [DAT_W-1:0] out_dat_q, out_dat_d;
  logic [ADR_W-1:0] out_adr_q, out_adr_d;
  logic [IDX_W-1:0] out_ch_q, out_ch_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NCH-1:0]   ovr_q, ovr_d;
  logic [NCH-1:0]   slot_full_q, slot_full_d;
  logic [DAT_W-1:0] slot_dat_q [NCH];
  logic [DAT_W-1:0] slot_dat_d [NCH];
  logic [ADR_W-1:0] slot_adr_q [NCH];
  logic [ADR_W-1:0] slot_adr_d [NCH];

  logic [NCH-1:0]   wr_ok;
  logic [NCH-1:0]   drain;
  logic             load;
  logic [IDX_W-1:0] pick_grant;
  logic             pick_any;

`ifdef AR_LABEL_FILTER_EN
  logic [255:0] mask_q, mask_d;

  // Label accept mask update and per-channel capture qualification against the current mask.
  always_comb begin
    mask_d = mask_q;
    if (lbl_wr) mask_d[lbl_sel] = lbl_acc;
    wr_ok = '0;
    for (int k = 0; k < NCH; k++) begin
      wr_ok[k] = ch_wr[k] & mask_q[ch_adr[ADR_W*k +: ADR_W]];
    end
  end

  // Mask comes out of reset accepting every label.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '1;
    else        mask_q <= mask_d;
  end
`else
  assign wr_ok = ch_wr;
`endif

  ar_rr_pick #(.NCH(NCH)) u_pick (
    .req   (slot_full_q),
    .last  (last_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Next-state, output-register load, slot drain/capture and overrun tracking.
  always_comb begin
    state_d     = state_q;
    out_dat_d   = out_dat_q;
    out_adr_d   = out_adr_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    slot_full_d = slot_full_q;
    slot_dat_d  = slot_dat_q;
    slot_adr_d  = slot_adr_q;
    ovr_d       = ovr_q & ~ovr_clr;
    drain       = '0;
    // The output register frees up when empty or when the current word is accepted this cycle.
    load        = pick_any && ((state_q == IDLE) || out_ready);

    case (state_q)
      IDLE:    if (pick_any) state_d = PRESENT;
      PRESENT: if (out_ready) state_d = pick_any ? PRESENT : IDLE;
      default: state_d = IDLE;
    endcase

    if (load) last_d = pick_grant;

    for (int k = 0; k < NCH; k++) begin
      drain[k] = load && (pick_grant == IDX_W'(k));
      if (drain[k]) begin
        out_dat_d      = slot_dat_q[k];
        out_adr_d      = slot_adr_q[k];
        out_ch_d       = IDX_W'(k);
        slot_full_d[k] = 1'b0;
      end
      // A slot draining this cycle has room for a new word; otherwise a full slot keeps its word.
      if (wr_ok[k]) begin
        if (!slot_full_q[k] || drain[k]) begin
          slot_dat_d[k]  = ch_dat[DAT_W*k +: DAT_W];
          slot_adr_d[k]  = ch_adr[ADR_W*k +: ADR_W];
          slot_full_d[k] = 1'b1;
        end else begin
          ovr_d[k] = 1'b1;
        end
      end
    end
  end

  // State registers; reset empties every slot and the output register at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_dat_q   <= '0;
      out_adr_q   <= '0;
      out_ch_q    <= '0;
      last_q      <= IDX_W'(NCH - 1);
      ovr_q       <= '0;
      slot_full_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        slot_dat_q[k] <= '0;
        slot_adr_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_dat_q   <= out_dat_d;
      out_adr_q   <= out_adr_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
      ovr_q       <= ovr_d;
      slot_full_q <= slot_full_d;
      slot_dat_q  <= slot_dat_d;
      slot_adr_q  <= slot_adr_d;
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign out_dat   = out_dat_q;
  assign out_adr   = out_adr_q;
  assign out_ch    = out_ch_q;
  assign ovr       = ovr_q;

endmodule
